// File: rtl/digital_clock_gen.sv
`default_nettype none
// ============================================================================
// Module   : digital_clock_gen
// Purpose  : Time-of-day clock with internal seconds prescaler, run/stop,
//            range-checked time/alarm loads, alarm pulse and 12/24-hour
//            BCD display digits.
// Revision : 1.0 - initial release
// ============================================================================
module digital_clock_gen #(
  parameter int TICKS_PER_SEC = 50000000,
  parameter int PRE_W         = $clog2(TICKS_PER_SEC)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic        time_ow,
  input  logic [16:0] time_in,
  input  logic        alarm_set,
  input  logic [16:0] alarm_in,
  input  logic        alarm_en,
  input  logic        mode_12h,
  output logic [16:0] time_out,
  output logic        sec_tick,
  output logic        alarm_hit,
  output logic        load_err,
  output logic        pm,
  output logic [3:0]  sec_1s,
  output logic [3:0]  sec_10s,
  output logic [3:0]  min_1s,
  output logic [3:0]  min_10s,
  output logic [3:0]  hr_1s,
  output logic [3:0]  hr_10s
);

  localparam logic [PRE_W-1:0] c_pre_max = PRE_W'(TICKS_PER_SEC - 1);

  logic [PRE_W-1:0] r_pre;
  logic [16:0]      r_time;
  logic [16:0]      r_alarm;
  logic             r_sec_tick;
  logic             r_alarm_hit;
  logic             r_load_err;

  logic [4:0]  w_hr;
  logic [5:0]  w_min;
  logic [5:0]  w_sec;
  logic [4:0]  w_nxt_hr;
  logic [5:0]  w_nxt_min;
  logic [5:0]  w_nxt_sec;
  logic [16:0] w_nxt_time;
  logic        w_wrap;
  logic        w_time_ok;
  logic        w_alarm_ok;
  logic [4:0]  w_hr_disp;

  assign w_hr  = r_time[16:12];
  assign w_min = r_time[11:6];
  assign w_sec = r_time[5:0];

  // The advance event is the prescaler wrap cycle, only while running
  assign w_wrap = run && (r_pre == c_pre_max);

  assign w_time_ok  = (time_in[16:12] <= 5'd23) && (time_in[11:6] <= 6'd59) &&
                      (time_in[5:0] <= 6'd59);
  assign w_alarm_ok = (alarm_in[16:12] <= 5'd23) && (alarm_in[11:6] <= 6'd59) &&
                      (alarm_in[5:0] <= 6'd59);

  // Time one second after the current time, with sec/min/hour carries
  always_comb begin
    w_nxt_sec = w_sec + 6'd1;
    w_nxt_min = w_min;
    w_nxt_hr  = w_hr;
    if (w_sec == 6'd59) begin
      w_nxt_sec = 6'd0;
      if (w_min == 6'd59) begin
        w_nxt_min = 6'd0;
        w_nxt_hr  = (w_hr == 5'd23) ? 5'd0 : w_hr + 5'd1;
      end else begin
        w_nxt_min = w_min + 6'd1;
      end
    end
  end

  assign w_nxt_time = {w_nxt_hr, w_nxt_min, w_nxt_sec};

  // Prescaler, time register and the registered pulse outputs; a valid time
  // load wins over a coincident advance and suppresses its tick and alarm
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pre       <= '0;
      r_time      <= '0;
      r_sec_tick  <= 1'b0;
      r_alarm_hit <= 1'b0;
    end else if (time_ow && w_time_ok) begin
      r_pre       <= '0;
      r_time      <= time_in;
      r_sec_tick  <= 1'b0;
      r_alarm_hit <= 1'b0;
    end else if (w_wrap) begin
      r_pre       <= '0;
      r_time      <= w_nxt_time;
      r_sec_tick  <= 1'b1;
      r_alarm_hit <= alarm_en && (w_nxt_time == r_alarm);
    end else begin
      if (run) begin
        r_pre <= r_pre + PRE_W'(1);
      end
      r_sec_tick  <= 1'b0;
      r_alarm_hit <= 1'b0;
    end
  end

  // Alarm register and the combined single-cycle load rejection pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_alarm    <= '0;
      r_load_err <= 1'b0;
    end else begin
      if (alarm_set && w_alarm_ok) begin
        r_alarm <= alarm_in;
      end
      r_load_err <= (time_ow && !w_time_ok) || (alarm_set && !w_alarm_ok);
    end
  end

  // Displayed hour: 12-hour mode maps 0 to 12 and 13..23 down by 12
  always_comb begin
    w_hr_disp = w_hr;
    if (mode_12h) begin
      if (w_hr == 5'd0) begin
        w_hr_disp = 5'd12;
      end else if (w_hr > 5'd12) begin
        w_hr_disp = w_hr - 5'd12;
      end
    end
  end

  assign time_out  = r_time;
  assign sec_tick  = r_sec_tick;
  assign alarm_hit = r_alarm_hit;
  assign load_err  = r_load_err;
  assign pm        = (w_hr >= 5'd12);

  assign sec_1s  = 4'(w_sec % 6'd10);
  assign sec_10s = 4'(w_sec / 6'd10);
  assign min_1s  = 4'(w_min % 6'd10);
  assign min_10s = 4'(w_min / 6'd10);
  assign hr_1s   = 4'(w_hr_disp % 5'd10);
  assign hr_10s  = 4'(w_hr_disp / 5'd10);

endmodule
`default_nettype wire

// File: tb/tb_digital_clock_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_digital_clock_gen
// Purpose  : Directed self-checking bench for digital_clock_gen with a
//            4-cycle second.
// Revision : 1.0 - initial release
// ============================================================================
module tb_digital_clock_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic        time_ow;
  logic [16:0] time_in;
  logic        alarm_set;
  logic [16:0] alarm_in;
  logic        alarm_en;
  logic        mode_12h;
  logic [16:0] time_out;
  logic        sec_tick;
  logic        alarm_hit;
  logic        load_err;
  logic        pm;
  logic [3:0]  sec_1s, sec_10s, min_1s, min_10s, hr_1s, hr_10s;

  int checks = 0;
  int errors = 0;

  digital_clock_gen #(.TICKS_PER_SEC(4)) dut (
    .clk(clk), .rst(rst), .run(run), .time_ow(time_ow), .time_in(time_in),
    .alarm_set(alarm_set), .alarm_in(alarm_in), .alarm_en(alarm_en),
    .mode_12h(mode_12h), .time_out(time_out), .sec_tick(sec_tick),
    .alarm_hit(alarm_hit), .load_err(load_err), .pm(pm),
    .sec_1s(sec_1s), .sec_10s(sec_10s), .min_1s(min_1s), .min_10s(min_10s),
    .hr_1s(hr_1s), .hr_10s(hr_10s)
  );

  always #5 clk = ~clk;

  function automatic logic [16:0] hms(input int h, input int m, input int s);
    return {5'(h), 6'(m), 6'(s)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_digits(input string tag, input int h10, input int h1,
                            input int m10, input int m1, input int s10, input int s1);
    chk({tag, ".hr_10s"}, 32'(hr_10s), 32'(h10));
    chk({tag, ".hr_1s"}, 32'(hr_1s), 32'(h1));
    chk({tag, ".min_10s"}, 32'(min_10s), 32'(m10));
    chk({tag, ".min_1s"}, 32'(min_1s), 32'(m1));
    chk({tag, ".sec_10s"}, 32'(sec_10s), 32'(s10));
    chk({tag, ".sec_1s"}, 32'(sec_1s), 32'(s1));
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; time_ow = 1'b0; time_in = '0; alarm_set = 1'b0;
    alarm_in = '0; alarm_en = 1'b0; mode_12h = 1'b0;

    // Reset state, both display modes
    step(3);
    chk("rst.time", 32'(time_out), 32'(hms(0, 0, 0)));
    chk("rst.tick", 32'(sec_tick), 0);
    chk("rst.alarm_hit", 32'(alarm_hit), 0);
    chk("rst.load_err", 32'(load_err), 0);
    chk("rst.pm", 32'(pm), 0);
    chk_digits("rst24", 0, 0, 0, 0, 0, 0);
    mode_12h = 1'b1;
    #1;
    chk_digits("rst12", 1, 2, 0, 0, 0, 0);
    chk("rst12.pm", 32'(pm), 0);
    mode_12h = 1'b0;

    // Free run: tick on every 4th edge, seconds 1..3
    @(negedge clk);
    rst = 1'b0; run = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step(1);
      chk($sformatf("run.tick%0d", k), 32'(sec_tick), 32'((k % 4) == 0));
      chk($sformatf("run.time%0d", k), 32'(time_out), 32'(hms(0, 0, k / 4)));
    end

    // Load 23:59:58, roll over to midnight
    time_ow = 1'b1; time_in = hms(23, 59, 58);
    step(1);
    time_ow = 1'b0;
    chk("ld.time", 32'(time_out), 32'(hms(23, 59, 58)));
    chk("ld.tick", 32'(sec_tick), 0);
    chk("ld.pm", 32'(pm), 1);
    step(4);
    chk("roll1.time", 32'(time_out), 32'(hms(23, 59, 59)));
    chk("roll1.tick", 32'(sec_tick), 1);
    step(4);
    chk("roll2.time", 32'(time_out), 32'(hms(0, 0, 0)));
    chk("roll2.tick", 32'(sec_tick), 1);
    chk("roll2.pm", 32'(pm), 0);
    chk_digits("roll2", 0, 0, 0, 0, 0, 0);

    // 12-hour display of 13:00:00, then switch back to 24-hour
    mode_12h = 1'b1; time_ow = 1'b1; time_in = hms(13, 0, 0);
    step(1);
    time_ow = 1'b0;
    chk_digits("h13_12", 0, 1, 0, 0, 0, 0);
    chk("h13_12.pm", 32'(pm), 1);
    mode_12h = 1'b0;
    #1;
    chk_digits("h13_24", 1, 3, 0, 0, 0, 0);
    chk("h13_24.time", 32'(time_out), 32'(hms(13, 0, 0)));
    chk("h13_24.pm", 32'(pm), 1);

    // Alarm fires on the advance into 10:00:05
    @(negedge clk);
    alarm_set = 1'b1; alarm_in = hms(10, 0, 5); alarm_en = 1'b1;
    time_ow = 1'b1; time_in = hms(10, 0, 4);
    step(1);
    alarm_set = 1'b0; time_ow = 1'b0;
    chk("al.load_err", 32'(load_err), 0);
    chk("al.hit0", 32'(alarm_hit), 0);
    step(3);
    chk("al.hit_pre", 32'(alarm_hit), 0);
    step(1);
    chk("al.time", 32'(time_out), 32'(hms(10, 0, 5)));
    chk("al.tick", 32'(sec_tick), 1);
    chk("al.hit", 32'(alarm_hit), 1);
    step(1);
    chk("al.hit_after", 32'(alarm_hit), 0);
    // Reloading the alarm time directly must not fire
    time_ow = 1'b1; time_in = hms(10, 0, 5);
    step(1);
    time_ow = 1'b0;
    chk("al.reload_time", 32'(time_out), 32'(hms(10, 0, 5)));
    chk("al.reload_hit", 32'(alarm_hit), 0);
    step(4);
    chk("al.next_time", 32'(time_out), 32'(hms(10, 0, 6)));
    chk("al.next_hit", 32'(alarm_hit), 0);

    // Invalid load (min = 60) is rejected with a single load_err pulse
    time_ow = 1'b1; time_in = hms(10, 60, 0);
    step(1);
    time_ow = 1'b0;
    chk("bad.load_err", 32'(load_err), 1);
    chk("bad.time", 32'(time_out), 32'(hms(10, 0, 6)));
    step(1);
    chk("bad.load_err_end", 32'(load_err), 0);
    step(1);
    // Valid load on the wrap cycle discards the advance
    time_ow = 1'b1; time_in = hms(5, 6, 7);
    step(1);
    time_ow = 1'b0;
    chk("wrapld.time", 32'(time_out), 32'(hms(5, 6, 7)));
    chk("wrapld.tick", 32'(sec_tick), 0);
    step(3);
    chk("wrapld.tick3", 32'(sec_tick), 0);
    step(1);
    chk("wrapld.tick4", 32'(sec_tick), 1);
    chk("wrapld.time4", 32'(time_out), 32'(hms(5, 6, 8)));
    // Invalid time and alarm loads on the wrap cycle: advance still happens
    step(3);
    time_ow = 1'b1; time_in = hms(24, 0, 0);
    alarm_set = 1'b1; alarm_in = hms(1, 2, 60);
    step(1);
    time_ow = 1'b0; alarm_set = 1'b0;
    chk("badwrap.load_err", 32'(load_err), 1);
    chk("badwrap.tick", 32'(sec_tick), 1);
    chk("badwrap.time", 32'(time_out), 32'(hms(5, 6, 9)));
    step(1);
    chk("badwrap.load_err_end", 32'(load_err), 0);

    // run = 0 freezes prescaler and time
    step(1);
    run = 1'b0;
    step(10);
    chk("stop.time", 32'(time_out), 32'(hms(5, 6, 9)));
    chk("stop.tick", 32'(sec_tick), 0);
    run = 1'b1;
    step(1);
    chk("resume.tick_early", 32'(sec_tick), 0);
    step(1);
    chk("resume.tick", 32'(sec_tick), 1);
    chk("resume.time", 32'(time_out), 32'(hms(5, 6, 10)));

    // Asynchronous reset mid-second
    step(2);
    #2 rst = 1'b1;
    #1;
    chk("arst.time", 32'(time_out), 32'(hms(0, 0, 0)));
    chk("arst.pm", 32'(pm), 0);
    @(negedge clk);
    rst = 1'b0;
    step(3);
    chk("arst.tick3", 32'(sec_tick), 0);
    step(1);
    chk("arst.tick4", 32'(sec_tick), 1);
    chk("arst.time4", 32'(time_out), 32'(hms(0, 0, 1)));
    // Alarm register cleared to 00:00:00 fires on midnight
    time_ow = 1'b1; time_in = hms(23, 59, 59);
    step(1);
    time_ow = 1'b0;
    step(4);
    chk("arst.alarm_time", 32'(time_out), 32'(hms(0, 0, 0)));
    chk("arst.alarm_hit", 32'(alarm_hit), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
